debug_trap_collect: RTL and testbench
=====================================

# debug_trap_collect

Consumes the per-breakpoint data-hit vector from the read-stage breakpoint matcher and the write-stage write-hit vector. Carries the hits alongside their instruction through the execute and write stages. On instruction retirement it updates DR6 and raises a debug trap (#DB) request to the exception logic. It sits between the read stage and the exception/retire logic of the pipeline.

## Interface
Parameters: none.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dr7  in  32  debug control; Ln/Gn enable bits [7:0]
- rd_debug_read  in  4  read-stage breakpoint hits B3..B0; sticky until rd_ready
- rd_ready  in  1  instruction leaves read stage (read→execute transfer)
- exe_ready  in  1  instruction leaves execute stage (execute→write transfer)
- wr_debug_write  in  4  write-stage breakpoint hits; valid in the wr_finished cycle
- wr_finished  in  1  instruction retires
- wr_tf  in  1  EFLAGS.TF as of the retiring instruction's start
- exc_init  in  1  pipeline flush; discards in-flight hits
- dr6_wr_do  in  1  software MOV DR6 write
- dr6_wr_value  in  32  value for that write
- debug_trap_ack  in  1  exception logic has accepted the trap
- dr6  out  32  debug status register; reset 32'hFFFF0FF0
- debug_trap_req  out  1  #DB request; reset 0

## Operation
- Hit pipeline: ex_hits[3:0] and wr_hits[3:0], both reset to 0.
  - On rd_ready: ex_hits <= rd_debug_read.
  - On exe_ready: wr_hits <= ex_hits.
  - Both in the same cycle: shift and load together; the old ex_hits goes to wr_hits.
  - On exc_init: both clear; exc_init overrides all loads.
- Retire hits: ret_hits = wr_hits | wr_debug_write, sampled when wr_finished=1.
- Enable: breakpoint n is enabled iff dr7[2n] | dr7[2n+1].
- DR6 update at retire:
  - Bn is ORed with ret_hits[n] regardless of enable.
  - BS (bit 14) is set if wr_tf=1 (see Configuration).
  - Existing B/BS bits are never cleared by hardware.
- Trap condition at retire: (ret_hits & enable_mask) != 0, or the BS condition.
- Software write: dr6 <= (dr6_wr_value & 32'h0000E00F) | 32'hFFFF0FF0.
  - Bits 31:16 and 11:4 read as 1; bit 12 reads as 0.
  - If a software write and a retire update occur in the same cycle, the written value is applied first, then the retire bits are ORed in.
- FSM:
  - IDLE → REQ on wr_finished with the trap condition true.
  - REQ → IDLE on debug_trap_ack.
  - In REQ, a further wr_finished still ORs its bits into DR6 but does not raise a second request.
  - exc_init does not cancel REQ.
- debug_trap_req = (state == REQ).

## Timing
- rd_debug_read is captured on the rd_ready edge; the sticky behaviour upstream makes any cycle up to and including rd_ready valid.
- Retire to DR6 update and debug_trap_req rise: 1 cycle; both are registered.
- debug_trap_req is held high until the ack cycle and drops the cycle after ack.
- An ack in the same cycle as the request's first visible cycle is legal: the request is 1 cycle wide.
- Reset mid-REQ: state → IDLE, req → 0, dr6 → FFFF0FF0, hit stages → 0.

## Configuration
- AO486_DEBUG_SINGLESTEP_EN defined:
  - wr_tf=1 at retire sets DR6.BS and satisfies the trap condition.
- Undefined:
  - wr_tf is ignored.
  - BS changes only by software write.
  - Data-breakpoint behaviour is unchanged.

## Structure
- Shared defines/package:
  - DR6 reset constant 32'hFFFF0FF0.
  - DR6 writable mask 32'h0000E00F.
  - BS bit index 14.
  - FSM encodings IDLE=1'b0, REQ=1'b1.
- One natural sub-module: debug_hit_stage, a 4-bit hit register with load, clear and flush.
  - Instantiated twice, for the ex and wr stages.

## Test plan
- **Read hit, enabled:** dr7=32'h00000001, rd_debug_read=4'b0001 at rd_ready, then exe_ready, then wr_finished → next cycle dr6=FFFF0FF1, debug_trap_req=1; ack → req=0 the cycle after.
- **Read hit, disabled:** dr7=0, rd_debug_read=4'b0100 carried to retire → dr6=FFFF0FF4, debug_trap_req stays 0.
- **Flush discards hit:** hit loaded into ex_hits, exc_init before exe_ready, then a clean retire → dr6 unchanged at FFFF0FF0, no request.
- **Write hit plus single step:** wr_debug_write=4'b1000, dr7=32'h00000080, wr_tf=1 with the macro defined → dr6=FFFF4FF8, req=1. Without the macro → dr6=FFFF0FF8.
- **Simultaneous software write and retire:** dr6_wr_do with value 0 in the same cycle as a retire with ret_hits=4'b0010 and dr7 bit 2 set → dr6=FFFF0FF2, req=1. A second wr_finished during REQ with hit B0 → dr6=FFFF0FF3, req still a single continuous assertion.

Source files
------------

// File: rtl/debug_trap_collect_pkg.sv
// Shared constants, FSM encoding and helpers for the debug trap collector.
// Optional single-step support is selected by AO486_DEBUG_SINGLESTEP_EN.
package debug_trap_collect_pkg;

    localparam logic [31:0] DR6_RESET   = 32'hFFFF0FF0;
    localparam logic [31:0] DR6_WR_MASK = 32'h0000E00F;
    localparam int unsigned DR6_BS_BIT  = 14;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } trap_state_e;

    // Breakpoint n is armed when either its local or global enable is set.
    function automatic logic [3:0] bp_enable_mask(input logic [7:0] dr7_en);
        logic [3:0] mask;
        for (int n = 0; n < 4; n++) begin
            mask[n] = dr7_en[2*n] | dr7_en[2*n+1];
        end
        return mask;
    endfunction

endpackage

// File: rtl/debug_trap_collect_hit_stage.sv
// One pipeline stage of breakpoint hits: a 4-bit register with load and flush.
// Flush wins over load so a squashed instruction never carries stale hits.
module debug_hit_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       flush,
    input  logic [3:0] load_value,
    output logic [3:0] hits
);

    logic [3:0] hits_d;
    logic [3:0] hits_q;

    always_comb begin
        hits_d = hits_q;
        if (flush) begin
            hits_d = '0;
        end else if (load) begin
            hits_d = load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign hits = hits_q;

endmodule

// File: rtl/debug_trap_collect.sv
// Carries breakpoint hits to retirement, updates DR6 and raises the #DB request.
// Define AO486_DEBUG_SINGLESTEP_EN to let EFLAGS.TF set DR6.BS and trap.
module debug_trap_collect
    import debug_trap_collect_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dr7,
    input  logic [3:0]  rd_debug_read,
    input  logic        rd_ready,
    input  logic        exe_ready,
    input  logic [3:0]  wr_debug_write,
    input  logic        wr_finished,
    input  logic        wr_tf,
    input  logic        exc_init,
    input  logic        dr6_wr_do,
    input  logic [31:0] dr6_wr_value,
    input  logic        debug_trap_ack,
    output logic [31:0] dr6,
    output logic        debug_trap_req
);

    logic [3:0]  ex_hits;
    logic [3:0]  wr_hits;
    logic [3:0]  ret_hits;
    logic [3:0]  enable_mask;
    logic        single_step;
    logic        trap_cond;
    logic [31:0] dr6_base;
    logic [31:0] dr6_d;
    logic [31:0] dr6_q;
    trap_state_e state_d;
    trap_state_e state_q;

    debug_hit_stage u_ex_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (rd_ready),
        .flush      (exc_init),
        .load_value (rd_debug_read),
        .hits       (ex_hits)
    );

    debug_hit_stage u_wr_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (exe_ready),
        .flush      (exc_init),
        .load_value (ex_hits),
        .hits       (wr_hits)
    );

`ifdef AO486_DEBUG_SINGLESTEP_EN
    logic [23:0] unused_dr7;
    assign unused_dr7  = dr7[31:8];
    assign single_step = wr_tf;
`else
    logic [24:0] unused_inputs;
    assign unused_inputs = {dr7[31:8], wr_tf};
    assign single_step   = 1'b0;
`endif

    assign ret_hits    = wr_hits | wr_debug_write;
    assign enable_mask = bp_enable_mask(dr7[7:0]);
    assign trap_cond   = wr_finished & ((|(ret_hits & enable_mask)) | single_step);

    // A software write lands first; retire bits are then ORed on top of it.
    always_comb begin
        dr6_base = dr6_q;
        if (dr6_wr_do) begin
            dr6_base = (dr6_wr_value & DR6_WR_MASK) | DR6_RESET;
        end
        dr6_d = dr6_base;
        if (wr_finished) begin
            dr6_d[3:0]        = dr6_base[3:0] | ret_hits;
            dr6_d[DR6_BS_BIT] = dr6_base[DR6_BS_BIT] | single_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dr6_q <= DR6_RESET;
        end else begin
            dr6_q <= dr6_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Retires while a request is pending only accumulate into DR6.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trap_cond) state_d = REQ;
            REQ:     if (debug_trap_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        debug_trap_req = (state_q == REQ);
    end

    assign dr6 = dr6_q;

endmodule

// File: tb/tb_debug_trap_collect.sv
// Self-checking bench for debug_trap_collect: directed scenarios then random traffic
// against a behavioural model. Honours AO486_DEBUG_SINGLESTEP_EN like the design.
module tb_debug_trap_collect;

    logic        clk;
    logic        rst_n;
    logic [31:0] dr7;
    logic [3:0]  rd_debug_read;
    logic        rd_ready;
    logic        exe_ready;
    logic [3:0]  wr_debug_write;
    logic        wr_finished;
    logic        wr_tf;
    logic        exc_init;
    logic        dr6_wr_do;
    logic [31:0] dr6_wr_value;
    logic        debug_trap_ack;
    logic [31:0] dr6;
    logic        debug_trap_req;

    int assertCount = 0;
    int failCount   = 0;

`ifdef AO486_DEBUG_SINGLESTEP_EN
    localparam bit SS_EN = 1'b1;
`else
    localparam bit SS_EN = 1'b0;
`endif

    // Reference model state: hits per in-flight stage, DR6 and pending trap.
    int unsigned mExHits;
    int unsigned mWrHits;
    int unsigned mDr6;
    bit          mTrapPending;

    debug_trap_collect dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dr7            (dr7),
        .rd_debug_read  (rd_debug_read),
        .rd_ready       (rd_ready),
        .exe_ready      (exe_ready),
        .wr_debug_write (wr_debug_write),
        .wr_finished    (wr_finished),
        .wr_tf          (wr_tf),
        .exc_init       (exc_init),
        .dr6_wr_do      (dr6_wr_do),
        .dr6_wr_value   (dr6_wr_value),
        .debug_trap_ack (debug_trap_ack),
        .dr6            (dr6),
        .debug_trap_req (debug_trap_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic idleInputs();
        rst_n          = 1'b1;
        rd_debug_read  = 4'h0;
        rd_ready       = 1'b0;
        exe_ready      = 1'b0;
        wr_debug_write = 4'h0;
        wr_finished    = 1'b0;
        wr_tf          = 1'b0;
        exc_init       = 1'b0;
        dr6_wr_do      = 1'b0;
        dr6_wr_value   = 32'h0;
        debug_trap_ack = 1'b0;
    endtask

    // Advance the model by one clock using the rules of the block, then clock the DUT and compare.
    task automatic applyStimulus(input string tag);
        int unsigned retired;
        int unsigned armed;
        bit          trapNow;
        int unsigned oldEx;
        armed = 0;
        for (int n = 0; n < 4; n++) begin
            if (dr7[2*n] || dr7[2*n+1]) armed += (1 << n);
        end
        if (!rst_n) begin
            mExHits      = 0;
            mWrHits      = 0;
            mDr6         = 32'hFFFF0FF0;
            mTrapPending = 1'b0;
        end else begin
            retired = mWrHits | wr_debug_write;
            if (dr6_wr_do) mDr6 = (dr6_wr_value & 32'h0000E00F) | 32'hFFFF0FF0;
            trapNow = 1'b0;
            if (wr_finished) begin
                mDr6 = mDr6 | retired;
                if (SS_EN && wr_tf) mDr6 = mDr6 | (1 << 14);
                trapNow = ((retired & armed) != 0) || (SS_EN && wr_tf);
            end
            if (mTrapPending) mTrapPending = !debug_trap_ack;
            else              mTrapPending = trapNow;
            oldEx = mExHits;
            if (exc_init) begin
                mExHits = 0;
                mWrHits = 0;
            end else begin
                if (exe_ready) mWrHits = oldEx;
                if (rd_ready)  mExHits = rd_debug_read;
            end
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_dr6"}, dr6, mDr6);
        checkOutput({tag, "_req"}, {31'b0, debug_trap_req}, {31'b0, mTrapPending});
        idleInputs();
    endtask

    task automatic doReset();
        idleInputs();
        rst_n = 1'b0;
        applyStimulus("reset");
        applyStimulus("post_reset");
    endtask

    initial begin
        dr7 = 32'h0;
        idleInputs();
        #1;

        doReset();
        checkOutput("reset_dr6_const", dr6, 32'hFFFF0FF0);
        checkOutput("reset_req_const", {31'b0, debug_trap_req}, 32'h0);

        $display("[TB] read hit, enabled");
        dr7 = 32'h00000001;
        rd_debug_read = 4'b0001; rd_ready = 1'b1;
        applyStimulus("t1_rd");
        exe_ready = 1'b1;
        applyStimulus("t1_exe");
        wr_finished = 1'b1;
        applyStimulus("t1_ret");
        checkOutput("t1_dr6_const", dr6, 32'hFFFF0FF1);
        checkOutput("t1_req_const", {31'b0, debug_trap_req}, 32'h1);
        debug_trap_ack = 1'b1;
        applyStimulus("t1_ack");
        checkOutput("t1_req_drop", {31'b0, debug_trap_req}, 32'h0);

        $display("[TB] read hit, disabled");
        doReset();
        dr7 = 32'h0;
        rd_debug_read = 4'b0100; rd_ready = 1'b1;
        applyStimulus("t2_rd");
        exe_ready = 1'b1;
        applyStimulus("t2_exe");
        wr_finished = 1'b1;
        applyStimulus("t2_ret");
        checkOutput("t2_dr6_const", dr6, 32'hFFFF0FF4);
        applyStimulus("t2_after");
        checkOutput("t2_req_const", {31'b0, debug_trap_req}, 32'h0);

        $display("[TB] flush discards hit");
        doReset();
        dr7 = 32'h000000FF;
        rd_debug_read = 4'b0001; rd_ready = 1'b1;
        applyStimulus("t3_rd");
        exc_init = 1'b1;
        applyStimulus("t3_flush");
        exe_ready = 1'b1;
        applyStimulus("t3_exe");
        wr_finished = 1'b1;
        applyStimulus("t3_ret");
        checkOutput("t3_dr6_const", dr6, 32'hFFFF0FF0);
        checkOutput("t3_req_const", {31'b0, debug_trap_req}, 32'h0);

        $display("[TB] write hit plus single step");
        doReset();
        dr7 = 32'h00000080;
        wr_debug_write = 4'b1000; wr_tf = 1'b1; wr_finished = 1'b1;
        applyStimulus("t4_ret");
        checkOutput("t4_dr6_const", dr6, SS_EN ? 32'hFFFF4FF8 : 32'hFFFF0FF8);
        checkOutput("t4_req_const", {31'b0, debug_trap_req}, 32'h1);
        debug_trap_ack = 1'b1;
        applyStimulus("t4_ack");

        $display("[TB] software write with retire");
        doReset();
        dr7 = 32'h00000004;
        rd_debug_read = 4'b0010; rd_ready = 1'b1;
        applyStimulus("t5_rd");
        exe_ready = 1'b1;
        applyStimulus("t5_exe");
        wr_finished = 1'b1; dr6_wr_do = 1'b1; dr6_wr_value = 32'h0;
        applyStimulus("t5_ret");
        checkOutput("t5_dr6_const", dr6, 32'hFFFF0FF2);
        checkOutput("t5_req_const", {31'b0, debug_trap_req}, 32'h1);
        wr_finished = 1'b1; wr_debug_write = 4'b0001;
        applyStimulus("t5_ret2");
        checkOutput("t5_dr6_const2", dr6, 32'hFFFF0FF3);
        checkOutput("t5_req_held", {31'b0, debug_trap_req}, 32'h1);
        debug_trap_ack = 1'b1;
        applyStimulus("t5_ack");
        checkOutput("t5_req_drop", {31'b0, debug_trap_req}, 32'h0);

        $display("[TB] software write masking");
        dr6_wr_do = 1'b1; dr6_wr_value = 32'h0000_FFFF;
        applyStimulus("t6_swr");
        checkOutput("t6_dr6_const", dr6, 32'hFFFFEFFF);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) dr7 = $urandom;
            rst_n          = ($urandom_range(0, 59) != 0);
            rd_debug_read  = 4'($urandom_range(0, 15));
            rd_ready       = 1'($urandom_range(0, 1));
            exe_ready      = 1'($urandom_range(0, 1));
            wr_debug_write = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            wr_finished    = 1'($urandom_range(0, 1));
            wr_tf          = ($urandom_range(0, 5) == 0);
            exc_init       = ($urandom_range(0, 7) == 0);
            dr6_wr_do      = ($urandom_range(0, 9) == 0);
            dr6_wr_value   = $urandom;
            debug_trap_ack = ($urandom_range(0, 2) == 0);
            applyStimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
